// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and byte-addressed data memory: queues stores,
// drains one per cycle, and forwards or stalls loads that overlap queued stores.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_wbits,
    input  logic [2:0]  req_rbits,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        sb_empty,
    output logic        dm_MemWr,
    output logic [1:0]  dm_MemWrBits,
    output logic        dm_MemR,
    output logic [2:0]  dm_MemRBits,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_data,
    input  logic [31:0] dm_rdata
);

    // Load type codes shared with the data memory.
    localparam logic [2:0] MemRLw  = 3'b000;
    localparam logic [2:0] MemRLh  = 3'b001;
    localparam logic [2:0] MemRLhu = 3'b010;
    localparam logic [2:0] MemRLb  = 3'b011;
    localparam logic [2:0] MemRLbu = 3'b100;

    localparam logic [1:0] WBitsIllegal = 2'b11;
    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        LdNoHit,
        LdFwd,
        LdStall
    } ld_class_e;

    function automatic logic [2:0] st_size(input logic [1:0] wbits);
        unique case (wbits)
            2'b00:   st_size = 3'd4;
            2'b01:   st_size = 3'd2;
            2'b10:   st_size = 3'd1;
            default: st_size = 3'd4;
        endcase
    endfunction

    function automatic logic [2:0] ld_size(input logic [2:0] rbits);
        case (rbits)
            MemRLh, MemRLhu: ld_size = 3'd2;
            MemRLb, MemRLbu: ld_size = 3'd1;
            default:         ld_size = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] rbits);
        case (rbits)
            MemRLw:  extend = d;
            MemRLh:  extend = {{16{d[15]}}, d[15:0]};
            MemRLhu: extend = {16'h0000, d[15:0]};
            MemRLb:  extend = {{24{d[7]}}, d[7:0]};
            MemRLbu: extend = {24'h000000, d[7:0]};
            default: extend = d;
        endcase
    endfunction

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [1:0]       bits_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ld_valid_q, ld_valid_d;
    logic [31:0]      ld_data_q, ld_data_d;

    logic             empty, full;
    logic             push, pop, ld_acc;
    logic [DEPTH-1:0] overlap;
    logic             hit;
    logic [PTR_W-1:0] young_idx;
    ld_class_e        ld_class;

    assign empty = (count_q == '0);
    assign full  = (count_q == FullCount);

    // Byte ranges use 33-bit arithmetic so a range ending at 0xFFFFFFFF cannot wrap.
    always_comb begin : overlap_calc
        logic [32:0] ld_lo, ld_hi, st_lo, st_hi;
        ld_lo   = {1'b0, req_addr};
        ld_hi   = ld_lo + {30'd0, ld_size(req_rbits)} - 33'd1;
        st_lo   = '0;
        st_hi   = '0;
        overlap = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            st_lo      = {1'b0, addr_q[i]};
            st_hi      = st_lo + {30'd0, st_size(bits_q[i])} - 33'd1;
            overlap[i] = valid_q[i] && (st_lo <= ld_hi) && (ld_lo <= st_hi);
        end
    end

    // Valid entries are contiguous from head in age order, so the last hit is the youngest.
    always_comb begin : youngest_calc
        logic [PTR_W-1:0] idx;
        idx       = '0;
        hit       = 1'b0;
        young_idx = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = head_q + PTR_W'(k);
            if (overlap[idx]) begin
                hit       = 1'b1;
                young_idx = idx;
            end
        end
    end

    // Illegal-size entries never write DM, so they cannot be forwarded either.
    always_comb begin
        ld_class = LdNoHit;
        if (hit) begin
            if ((addr_q[young_idx] == req_addr) && (bits_q[young_idx] != WBitsIllegal) &&
                (st_size(bits_q[young_idx]) >= ld_size(req_rbits))) begin
                ld_class = LdFwd;
            end else begin
                ld_class = LdStall;
            end
        end
    end

    always_comb begin
        req_ready = 1'b0;
        if (req_wr) begin
            req_ready = !full;
        end else begin
            unique case (ld_class)
                LdNoHit: req_ready = empty;
                LdFwd:   req_ready = 1'b1;
                LdStall: req_ready = 1'b0;
                default: req_ready = 1'b0;
            endcase
        end
    end

    assign push   = req_valid && req_wr && !full;
    assign pop    = !empty;
    assign ld_acc = req_valid && !req_wr && req_ready;

    // The single DM address port belongs to the drain whenever anything is queued.
    assign dm_MemWr     = !empty;
    assign dm_MemWrBits = bits_q[head_q];
    assign dm_data      = data_q[head_q];
    assign dm_addr      = empty ? req_addr : addr_q[head_q];
    assign dm_MemR      = req_valid && !req_wr && (ld_class == LdNoHit) && empty;
    assign dm_MemRBits  = req_rbits;

    always_comb begin
        valid_d = valid_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
        end
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end

    always_comb begin
        ld_valid_d = ld_acc;
        ld_data_d  = ld_data_q;
        if (ld_acc) begin
            ld_data_d = (ld_class == LdFwd) ? extend(data_q[young_idx], req_rbits) : dm_rdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                bits_q[i] <= '0;
            end
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ld_valid_q <= 1'b0;
            ld_data_q  <= '0;
        end else begin
            if (push) begin
                addr_q[tail_q] <= req_addr;
                data_q[tail_q] <= req_wdata;
                bits_q[tail_q] <= req_wbits;
            end
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ld_valid_q <= ld_valid_d;
            ld_data_q  <= ld_data_d;
        end
    end

    assign ld_valid = ld_valid_q;
    assign ld_data  = ld_data_q;
    assign sb_empty = empty;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic checked
// against a model of architectural memory (drained image overlaid with pending stores).
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011, LBU = 3'b100;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_wbits;
    logic [2:0]  req_rbits;
    logic        ld_valid, sb_empty, dm_MemWr, dm_MemR;
    logic [31:0] ld_data, dm_addr, dm_data, dm_rdata;
    logic [1:0]  dm_MemWrBits;
    logic [2:0]  dm_MemRBits;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wbits(req_wbits),
        .req_rbits(req_rbits), .ld_valid(ld_valid), .ld_data(ld_data),
        .sb_empty(sb_empty), .dm_MemWr(dm_MemWr), .dm_MemWrBits(dm_MemWrBits),
        .dm_MemR(dm_MemR), .dm_MemRBits(dm_MemRBits), .dm_addr(dm_addr),
        .dm_data(dm_data), .dm_rdata(dm_rdata)
    );

    function automatic int st_sz(input logic [1:0] b);
        return (b == 2'b00) ? 4 : (b == 2'b01) ? 2 : (b == 2'b10) ? 1 : 4;
    endfunction

    function automatic int ld_sz(input logic [2:0] r);
        return (r == LH || r == LHU) ? 2 : (r == LB || r == LBU) ? 1 : 4;
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] d, input logic [2:0] r);
        case (r)
            LH:      return {{16{d[15]}}, d[15:0]};
            LHU:     return {16'h0, d[15:0]};
            LB:      return {{24{d[7]}}, d[7:0]};
            LBU:     return {24'h0, d[7:0]};
            default: return d;
        endcase
    endfunction

    // Data memory: writes on negedge, combinational extended read.
    logic [7:0] dm_mem [0:1023];
    logic [9:0] ra;
    logic [31:0] raw_rd;
    assign ra     = dm_addr[9:0];
    assign raw_rd = {dm_mem[ra + 10'd3], dm_mem[ra + 10'd2], dm_mem[ra + 10'd1], dm_mem[ra]};
    assign dm_rdata = ext(raw_rd, dm_MemRBits);

    always @(negedge clk) begin
        int n;
        if (dm_MemWr) begin
            n = (dm_MemWrBits == 2'b00) ? 4 : (dm_MemWrBits == 2'b01) ? 2 :
                (dm_MemWrBits == 2'b10) ? 1 : 0;
            for (int b = 0; b < n; b++) dm_mem[dm_addr[9:0] + 10'(b)] = dm_data[8*b +: 8];
        end
    end

    // Reference model: drained memory image plus queue of accepted, undrained stores.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  bits;
    } st_t;
    st_t        pq[$];
    logic [7:0] ref_mem [0:1023];
    bit         nxt_ldv;
    logic [31:0] nxt_ldd;

    function automatic logic [31:0] arch_word(input logic [31:0] a);
        logic [31:0] w;
        logic [32:0] p, lo;
        int off;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            p = {1'b0, a} + 33'(b);
            w[8*b +: 8] = ref_mem[p[9:0]];
            foreach (pq[i]) begin
                lo = {1'b0, pq[i].addr};
                if (pq[i].bits != 2'b11 && p >= lo && p < lo + 33'(st_sz(pq[i].bits))) begin
                    off = int'(p - lo);
                    w[8*b +: 8] = pq[i].data[8*off +: 8];
                end
            end
        end
        return w;
    endfunction

    // 0 = no overlap, 1 = forward, 2 = stall
    function automatic int classify(input logic [31:0] a, input logic [2:0] r);
        int y;
        logic [32:0] llo, lhi, slo, shi;
        y   = -1;
        llo = {1'b0, a};
        lhi = llo + 33'(ld_sz(r)) - 33'd1;
        foreach (pq[i]) begin
            slo = {1'b0, pq[i].addr};
            shi = slo + 33'(st_sz(pq[i].bits)) - 33'd1;
            if (slo <= lhi && llo <= shi) y = i;
        end
        if (y < 0) return 0;
        if (pq[y].addr == a && pq[y].bits != 2'b11 && st_sz(pq[y].bits) >= ld_sz(r)) return 1;
        return 2;
    endfunction

    int n_vec = 0, n_bad = 0;
    logic obs_ready, obs_memwr, obs_memr, obs_empty, obs_ldv;
    logic [31:0] obs_addr, obs_data, obs_ldd;
    logic [1:0] obs_wbits;
    bit exp_ready, exp_memwr, exp_memr, exp_empty, exp_ldv, last_acc;
    logic [31:0] exp_addr, exp_data, exp_ldd;

    // One request cycle; starts and ends 1 time unit after a posedge.
    task automatic drive_cycle(input bit v, input bit wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [1:0] wb, input logic [2:0] rb);
        int cls, n;
        st_t e;
        obs_ldv = ld_valid; obs_ldd = ld_data; exp_ldv = nxt_ldv; exp_ldd = nxt_ldd;
        req_valid = v; req_wr = wr; req_addr = a; req_wdata = wd; req_wbits = wb; req_rbits = rb;
        #3;
        obs_ready = req_ready; obs_memwr = dm_MemWr; obs_memr = dm_MemR; obs_empty = sb_empty;
        obs_addr = dm_addr; obs_data = dm_data; obs_wbits = dm_MemWrBits;
        cls = classify(a, rb);
        exp_empty = (pq.size() == 0);
        exp_memwr = !exp_empty;
        exp_ready = wr ? (pq.size() < DEPTH) : (cls == 1 || (cls == 0 && exp_empty));
        exp_memr  = v && !wr && cls == 0 && exp_empty;
        exp_addr  = a;
        exp_data  = '0;
        if (!exp_empty) begin
            exp_addr = pq[0].addr;
            exp_data = pq[0].data;
        end
        last_acc = v && exp_ready;
        if (last_acc && !wr) begin
            nxt_ldv = 1'b1;
            nxt_ldd = ext(arch_word(a), rb);
        end else begin
            nxt_ldv = 1'b0;
        end
        if (!exp_empty) begin
            n = (pq[0].bits == 2'b11) ? 0 : st_sz(pq[0].bits);
            for (int b = 0; b < n; b++) ref_mem[pq[0].addr[9:0] + 10'(b)] = pq[0].data[8*b +: 8];
            void'(pq.pop_front());
        end
        if (last_acc && wr) begin
            e.addr = a; e.data = wd; e.bits = wb;
            pq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, LW);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = 1'b0;
        pq.delete();
        nxt_ldv = 1'b0;
        nxt_ldd = '0;
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        n_vec++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL por_empty: got %b want 1", sb_empty); end
        n_vec++; if (dm_MemWr !== 1'b0) begin n_bad++; $display("FAIL por_memwr: got %b want 0", dm_MemWr); end
        n_vec++; if (ld_valid !== 1'b0 || ld_data !== 32'h0) begin
            n_bad++; $display("FAIL por_ld: got %b/%h want 0/00000000", ld_valid, ld_data); end
        release_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 32'h300 + 32'(4*i), 32'hA5A5_0000 + 32'(i), 2'b00, LW);
        n_vec++; if (sb_empty !== 1'b0) begin n_bad++; $display("FAIL rst_pre_empty: got %b want 0", sb_empty); end
        do_reset();
        n_vec++; if (sb_empty !== 1'b1 || dm_MemWr !== 1'b0) begin
            n_bad++; $display("FAIL rst_async: empty %b memwr %b want 1 0", sb_empty, dm_MemWr); end
        release_reset();
        drive_cycle(1'b1, 1'b0, 32'h300, 32'h0, 2'b00, LW);
        n_vec++; if (ld_valid !== 1'b1) begin n_bad++; $display("FAIL rst_ld_pre: got %b want 1", ld_valid); end
        do_reset();
        n_vec++; if (ld_valid !== 1'b0 || ld_data !== 32'h0) begin
            n_bad++; $display("FAIL rst_ld_clear: got %b/%h want 0/00000000", ld_valid, ld_data); end
        release_reset();
    endtask

    task automatic test_back_to_back();
        logic [31:0] seen[$];
        logic [31:0] w;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive_cycle(1'b1, 1'b1, 32'(4*i), 32'hD000_0001 + 32'(i), 2'b00, LW);
            else idle();
            if (obs_memwr) seen.push_back(obs_addr);
            if (i < 5) begin
                n_vec++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready%0d: got %b want 1", i, obs_ready); end
            end
        end
        n_vec++;
        if (seen.size() != 5 || seen[0] != 0 || seen[1] != 4 || seen[2] != 8 || seen[3] != 12 || seen[4] != 16) begin
            n_bad++; $display("FAIL b2b_order: got %0d drains, first %h want 5 drains 0,4,8,12,16", seen.size(),
                              (seen.size() > 0) ? seen[0] : 32'hx);
        end
        for (int i = 0; i < 5; i++) begin
            w = {dm_mem[4*i+3], dm_mem[4*i+2], dm_mem[4*i+1], dm_mem[4*i]};
            n_vec++; if (w !== 32'hD000_0001 + 32'(i)) begin
                n_bad++; $display("FAIL b2b_dm%0d: got %h want %h", i, w, 32'hD000_0001 + 32'(i)); end
        end
    endtask

    task automatic test_stall_lbu();
        drive_cycle(1'b1, 1'b1, 32'h20, 32'h1122_3344, 2'b00, LW);
        drive_cycle(1'b1, 1'b0, 32'h21, 32'h0, 2'b00, LBU);
        n_vec++; if (obs_ready !== 1'b0 || obs_memr !== 1'b0) begin
            n_bad++; $display("FAIL lbu_stall: ready %b memr %b want 0 0", obs_ready, obs_memr); end
        drive_cycle(1'b1, 1'b0, 32'h21, 32'h0, 2'b00, LBU);
        n_vec++; if (obs_ready !== 1'b1 || obs_memr !== 1'b1 || obs_addr !== 32'h21) begin
            n_bad++; $display("FAIL lbu_accept: ready %b memr %b addr %h want 1 1 00000021",
                              obs_ready, obs_memr, obs_addr); end
        idle();
        n_vec++; if (obs_ldv !== 1'b1 || obs_ldd !== 32'h0000_0033) begin
            n_bad++; $display("FAIL lbu_data: got %b/%h want 1/00000033", obs_ldv, obs_ldd); end
    endtask

    task automatic test_fwd_lh();
        drive_cycle(1'b1, 1'b1, 32'h40, 32'h8000_F0A5, 2'b00, LW);
        drive_cycle(1'b1, 1'b0, 32'h40, 32'h0, 2'b00, LH);
        n_vec++; if (obs_ready !== 1'b1 || obs_memr !== 1'b0) begin
            n_bad++; $display("FAIL fwd_lh_hs: ready %b memr %b want 1 0", obs_ready, obs_memr); end
        idle();
        n_vec++; if (obs_ldv !== 1'b1 || obs_ldd !== 32'hFFFF_F0A5) begin
            n_bad++; $display("FAIL fwd_lh_data: got %b/%h want 1/fffff0a5", obs_ldv, obs_ldd); end
    endtask

    task automatic test_youngest();
        drive_cycle(1'b1, 1'b1, 32'h50, 32'h0000_007F, 2'b10, LW);
        drive_cycle(1'b1, 1'b1, 32'h50, 32'h0000_0081, 2'b10, LW);
        drive_cycle(1'b1, 1'b0, 32'h50, 32'h0, 2'b00, LB);
        n_vec++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL young_ready: got %b want 1", obs_ready); end
        idle();
        n_vec++; if (obs_ldv !== 1'b1 || obs_ldd !== 32'hFFFF_FF81) begin
            n_bad++; $display("FAIL young_data: got %b/%h want 1/ffffff81", obs_ldv, obs_ldd); end
        idle();
    endtask

    task automatic test_empty_lw();
        logic [31:0] v;
        v = 32'hDEAD_BEEF;
        for (int b = 0; b < 4; b++) begin
            dm_mem[10'h100 + 10'(b)]  = v[8*b +: 8];
            ref_mem[10'h100 + 10'(b)] = v[8*b +: 8];
        end
        idle();
        drive_cycle(1'b1, 1'b0, 32'h100, 32'h0, 2'b00, LW);
        n_vec++; if (obs_ready !== 1'b1 || obs_memr !== 1'b1 || obs_addr !== 32'h100) begin
            n_bad++; $display("FAIL lw_hs: ready %b memr %b addr %h want 1 1 00000100", obs_ready, obs_memr, obs_addr); end
        drive_cycle(1'b1, 1'b1, 32'h104, 32'h0BAD_F00D, 2'b00, LW);
        n_vec++; if (obs_ldv !== 1'b1 || obs_ldd !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL lw_data: got %b/%h want 1/deadbeef", obs_ldv, obs_ldd); end
        n_vec++; if (obs_ready !== 1'b1 || sb_empty !== 1'b0) begin
            n_bad++; $display("FAIL ld_then_st: ready %b empty %b want 1 0", obs_ready, sb_empty); end
        idle();
        idle();
    endtask

    task automatic test_illegal();
        drive_cycle(1'b1, 1'b1, 32'h80, 32'hCAFE_BABE, 2'b00, LW);
        idle();
        drive_cycle(1'b1, 1'b1, 32'h80, 32'h1234_5678, 2'b11, LW);
        n_vec++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL ill_accept: got %b want 1", obs_ready); end
        idle();
        n_vec++; if (obs_memwr !== 1'b1 || obs_wbits !== 2'b11) begin
            n_bad++; $display("FAIL ill_drain: memwr %b bits %b want 1 11", obs_memwr, obs_wbits); end
        idle();
        drive_cycle(1'b1, 1'b0, 32'h80, 32'h0, 2'b00, LW);
        idle();
        n_vec++; if (obs_ldv !== 1'b1 || obs_ldd !== 32'hCAFE_BABE) begin
            n_bad++; $display("FAIL ill_nowrite: got %b/%h want 1/cafebabe", obs_ldv, obs_ldd); end
    endtask

    task automatic test_random();
        bit pend, p_wr;
        logic [31:0] p_addr, p_wdata;
        logic [1:0] p_wbits;
        logic [2:0] p_rbits;
        pend = 1'b0; p_wr = 1'b0; p_addr = '0; p_wdata = '0; p_wbits = '0; p_rbits = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend    = 1'b1;
                p_wr    = 1'($urandom_range(0, 1));
                p_addr  = 32'h200 + 32'($urandom_range(0, 15));
                p_wdata = $urandom;
                p_wbits = 2'($urandom_range(0, 2));
                p_rbits = 3'($urandom_range(0, 4));
            end
            drive_cycle(pend, p_wr, p_addr, p_wdata, p_wbits, p_rbits);
            if (last_acc) pend = 1'b0;
            n_vec++; if (obs_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, obs_ready, exp_ready); end
            n_vec++; if (obs_memwr !== exp_memwr || obs_empty !== exp_empty) begin
                n_bad++; $display("FAIL rnd_drain c%0d: memwr %b empty %b want %b %b", c, obs_memwr, obs_empty, exp_memwr, exp_empty); end
            n_vec++; if (obs_memr !== exp_memr) begin n_bad++; $display("FAIL rnd_memr c%0d: got %b want %b", c, obs_memr, exp_memr); end
            n_vec++; if (obs_addr !== exp_addr) begin n_bad++; $display("FAIL rnd_addr c%0d: got %h want %h", c, obs_addr, exp_addr); end
            if (exp_memwr) begin
                n_vec++; if (obs_data !== exp_data) begin n_bad++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, obs_data, exp_data); end
            end
            n_vec++; if (obs_ldv !== exp_ldv || obs_ldd !== exp_ldd) begin
                n_bad++; $display("FAIL rnd_ld c%0d: got %b/%h want %b/%h", c, obs_ldv, obs_ldd, exp_ldv, exp_ldd); end
        end
        for (int i = 0; i < DEPTH + 2; i++) idle();
    endtask

    task automatic test_final_image();
        int diffs;
        diffs = 0;
        for (int i = 0; i < 1024; i++) if (dm_mem[i] !== ref_mem[i]) diffs++;
        n_vec++; if (diffs != 0) begin n_bad++; $display("FAIL final_image: got %0d differing bytes want 0", diffs); end
    endtask

    initial begin
        rstn = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_wbits = '0; req_rbits = '0;
        nxt_ldv = 1'b0; nxt_ldd = '0;
        for (int i = 0; i < 1024; i++) begin
            dm_mem[i]  = 8'($urandom);
            ref_mem[i] = dm_mem[i];
        end
        @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_stall_lbu();
        test_fwd_lh();
        test_youngest();
        test_empty_lw();
        test_illegal();
        test_random();
        test_final_image();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
